neuron_par_mac: RTL
===================

# neuron_par_mac

- Parametrised multi-lane fully-connected neuron: accepts `lanes` inputs per beat and multiplies each by a weight from a runtime-loadable local weight memory.
- Accumulates in a widened, overflow-free accumulator, then adds a runtime-loadable bias.
- Applies ReLU or linear activation with output saturation; the ROM sigmoid path stays external.
- Sits in each FC layer in place of single-lane neurons. Configuration uses the shared weight/bias config bus; data moves on a valid/ready input stream with a one-cycle result pulse.

## Interface
- layerNo, 1, layer id matched against config_layer_num
- neuronNo, 0, neuron id matched against config_neuron_num
- numWeight, 784, weights per neuron (≥1)
- dataWidth, 16, signed fixed-point width of inputs, weights, bias, out
- lanes, 4, products per beat (≥1); numBeats = ceil(numWeight/lanes)
- weightIntWidth, 1, integer bits of the data format; output shift = dataWidth-weightIntWidth
- actType, "relu", "relu" or "linear"
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- myinput  in  lanes*dataWidth  lane k = bits [k*dataWidth +: dataWidth], signed
- myinputValid  in  1  beat valid
- myinputReady  out  1  beat accepted when valid&ready
- weightValid  in  1  config weight write strobe
- biasValid  in  1  config bias write strobe
- weightValue  in  32  weight, low dataWidth bits used
- biasValue  in  32  bias, low dataWidth bits used
- config_layer_num  in  32  target layer of config write
- config_neuron_num  in  32  target neuron of config write
- out  out  dataWidth  activated result, held until next result
- outvalid  out  1  one-cycle result pulse
- satFlag  out  1  valid with outvalid; 1 = result clipped

## Operation
- Config match: cfg = (config_layer_num==layerNo)&(config_neuron_num==neuronNo).
- Weight load: weightValid&cfg writes weightValue[dataWidth-1:0] at load pointer p (word p/lanes, lane p%lanes), then p increments. p wraps to 0 after numWeight-1.
- Bias load: biasValid&cfg loads biasReg. Simultaneous weight and bias writes are both performed.
- Weight/bias writes while a vector is in flight are allowed, but the result is undefined.
- States:
  - ACCUM: ready=1; beat counter b counts accepted beats. Acceptance with b==numBeats-1 moves to DRAIN and clears b.
  - DRAIN: ready=0 for 5 cycles, then returns to ACCUM.
- Pipeline per accepted beat, each stage registered:
  - S1: weight word read, input latched.
  - S2: lanes signed dataWidth×dataWidth products, 2*dataWidth bits each.
  - S3: lane sum.
  - S4: accumulate. The first beat of a vector loads the lane sum rather than adding it. A first/last tag travels with the data.
  - S5: bias add + activation → out.
- Lane masking: on the last beat, lanes with global index ≥ numWeight contribute 0 regardless of input or weight data.
- Accumulator width accW = 2*dataWidth + clog2(numWeight) + 1. It never overflows internally.
- Bias alignment: biasReg is sign-extended to accW and shifted left by dataWidth before the add.
- Activation on t = (acc + bias) >>> (dataWidth-weightIntWidth), arithmetic shift:
  - relu: t<0 → 0, satFlag=0; t>2^(dataWidth-1)-1 → 0x7FFF-style max, satFlag=1; else t.
  - linear: clip to [-2^(dataWidth-1), 2^(dataWidth-1)-1]; satFlag=1 if clipped.

## Timing
- Reset values: myinputReady=1 (state ACCUM), outvalid=0, satFlag=0, out=0, b=0, p=0, biasReg=0, all pipeline valids 0. Weight memory contents are not cleared.
- Latency: outvalid rises exactly 5 clocks after the edge that accepts the last beat.
- myinputReady is low during those 5 cycles and high again in the outvalid cycle.
- Throughput: one beat/cycle in ACCUM. Per vector: numBeats+5 cycles.
- numBeats==1: every accepted beat is both first and last.
- outvalid is never asserted twice for one vector, and never for a partial vector.
- Reset mid-vector or mid-drain: partial sum and in-flight tags are discarded, with no outvalid. The next beat after reset is first of a new vector.
- myinputValid low mid-vector: stall without bound; b and acc hold.

## Test plan
- numWeight=8, lanes=4, all weights 0x4000, inputs 0x1000, bias 0 -> out=0x4000, satFlag=0, outvalid exactly 5 cycles after the 2nd beat. Same run with bias 0x0800 -> out=0x5000.
- numWeight=6, lanes=4, weights 0x4000, inputs 0x1000, masked lanes driven 0x7FFF -> out=0x3000 (masked lanes ignored).
- Inputs 0xF000, weights 0x4000, numWeight=8:
  - relu -> out=0x0000, satFlag=0.
  - linear -> out=0xC000.
- Inputs and weights 0x7FFF, numWeight=8, relu -> out=0x7FFF, satFlag=1.
- Config filtering and wrap:
  - weightValid with config_neuron_num≠neuronNo -> memory unchanged, result unchanged.
  - numWeight+1 matched writes -> the last write overwrites address 0.
- Protocol:
  - rst asserted after beat 1 of 2 -> no outvalid; the next full vector gives a single correct result.
  - myinputValid held high across two vectors -> ready low for exactly 5 cycles between vectors; two outvalid pulses.

Source files
------------

// File: rtl/neuron_par_mac.sv
// Purpose: multi-lane fully-connected neuron; loadable weights/bias, widened accumulate, ReLU/linear with saturation.
// Latency: outvalid pulses 5 clocks after the edge that accepts the last beat of a vector.
// Backpressure: myinputReady high while accumulating, low for the 5 drain cycles after the last beat.
module neuron_par_mac #(
  parameter int    layerNo        = 1,
  parameter int    neuronNo       = 0,
  parameter int    numWeight      = 784,
  parameter int    dataWidth      = 16,
  parameter int    lanes          = 4,
  parameter int    weightIntWidth = 1,
  parameter string actType        = "relu"
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [lanes*dataWidth-1:0]   myinput,
  input  logic                         myinputValid,
  output logic                         myinputReady,
  input  logic                         weightValid,
  input  logic                         biasValid,
  input  logic [31:0]                  weightValue,
  input  logic [31:0]                  biasValue,
  input  logic [31:0]                  config_layer_num,
  input  logic [31:0]                  config_neuron_num,
  output logic [dataWidth-1:0]         out,
  output logic                         outvalid,
  output logic                         satFlag
);

  localparam int NB         = (numWeight + lanes - 1) / lanes;
  localparam int LAST_LANES = numWeight - (NB - 1) * lanes;
  localparam int PW         = 2 * dataWidth;
  localparam int ACCW       = 2 * dataWidth + $clog2(numWeight) + 1;
  localparam int SW         = ACCW + 1;
  localparam int SH         = dataWidth - weightIntWidth;
  localparam int BW         = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW         = (lanes > 1) ? $clog2(lanes) : 1;
  localparam bit IS_LIN     = (actType == "linear");
  localparam logic signed [SW-1:0] MAXV = {{(SW-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  typedef enum logic {ACCUM, DRAIN} state_t;

  // Configuration bus: weight memory, load pointer, bias
  logic                         cfg;
  logic [lanes*dataWidth-1:0]   wmem [NB];
  logic [BW-1:0]                wptr;
  logic [LW-1:0]                lptr;
  logic [dataWidth-1:0]         bias_reg;
  logic                         unused_cfg_bits;

  // Beat sequencing
  state_t                       state, state_nxt;
  logic [BW-1:0]                beat, beat_nxt;
  logic [2:0]                   dcnt, dcnt_nxt;
  logic                         accept;

  // Pipeline
  logic                         s0_vld, s1_vld, s2_vld, s3_vld, s4_vld;
  logic                         s0_first, s1_first, s2_first, s3_first;
  logic                         s0_last, s1_last, s2_last, s3_last, s4_last;
  logic [lanes*dataWidth-1:0]   s0_dat;
  logic [BW-1:0]                s0_beat;
  logic [lanes*dataWidth-1:0]   lane_mask;
  logic [lanes*dataWidth-1:0]   s1_w, s1_x;
  logic signed [PW-1:0]         s2_prod [lanes];
  logic signed [ACCW-1:0]       lane_sum, s3_sum, acc;
  logic signed [SW-1:0]         bias_ext, pre, t;
  logic [dataWidth-1:0]         act_out;
  logic                         act_sat;

  assign cfg = (config_layer_num == 32'(layerNo)) && (config_neuron_num == 32'(neuronNo));
  assign unused_cfg_bits = ^{weightValue[31:dataWidth], biasValue[31:dataWidth]};

  // Load pointer walks lanes then words, wrapping after the last real weight
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      lptr     <= '0;
      bias_reg <= '0;
    end else begin
      if (weightValid && cfg) begin
        if (wptr == BW'(NB - 1) && lptr == LW'(LAST_LANES - 1)) begin
          wptr <= '0;
          lptr <= '0;
        end else if (lptr == LW'(lanes - 1)) begin
          lptr <= '0;
          wptr <= wptr + BW'(1);
        end else begin
          lptr <= lptr + LW'(1);
        end
      end
      if (biasValid && cfg) bias_reg <= biasValue[dataWidth-1:0];
    end
  end

  // Weight memory write; contents survive reset
  always_ff @(posedge clk) begin
    if (weightValid && cfg) wmem[wptr][lptr*dataWidth +: dataWidth] <= weightValue[dataWidth-1:0];
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      beat  <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Sequencer next state: accept beats, then hold off input while the vector drains
  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat;
    dcnt_nxt     = dcnt;
    myinputReady = 1'b0;
    case (state)
      ACCUM: begin
        myinputReady = 1'b1;
        if (myinputValid) begin
          if (beat == BW'(NB - 1)) begin
            beat_nxt  = '0;
            dcnt_nxt  = '0;
            state_nxt = DRAIN;
          end else begin
            beat_nxt = beat + BW'(1);
          end
        end
      end
      DRAIN: begin
        if (dcnt == 3'd4) begin
          dcnt_nxt  = '0;
          state_nxt = ACCUM;
        end else begin
          dcnt_nxt = dcnt + 3'd1;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  assign accept = myinputValid && myinputReady;

  // Zero both operands of lanes beyond the last real weight on the final beat
  always_comb begin
    lane_mask = '1;
    for (int k = 0; k < lanes; k++) begin
      if (s0_last && (k >= LAST_LANES)) lane_mask[k*dataWidth +: dataWidth] = '0;
    end
  end

  // Sign-extended lane products summed at accumulator width
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < lanes; k++) begin
      lane_sum = lane_sum + {{(ACCW-PW){s2_prod[k][PW-1]}}, s2_prod[k]};
    end
  end

  // Bias add at product scale, rescale, then activation and clipping
  always_comb begin
    bias_ext = {{(SW-dataWidth){bias_reg[dataWidth-1]}}, bias_reg};
    pre      = {acc[ACCW-1], acc} + (bias_ext <<< dataWidth);
    t        = pre >>> SH;
    act_out  = t[dataWidth-1:0];
    act_sat  = 1'b0;
    if (t > MAXV) begin
      act_out = MAXV[dataWidth-1:0];
      act_sat = 1'b1;
    end else if (t < MINV) begin
      act_out = IS_LIN ? MINV[dataWidth-1:0] : '0;
      act_sat = IS_LIN;
    end else if (!IS_LIN && t < 0) begin
      act_out = '0;
    end
  end

  // Pipeline valids and the registered result; reset drops any in-flight vector
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld   <= 1'b0;
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      s3_vld   <= 1'b0;
      s4_vld   <= 1'b0;
      outvalid <= 1'b0;
      out      <= '0;
      satFlag  <= 1'b0;
    end else begin
      s0_vld   <= accept;
      s1_vld   <= s0_vld;
      s2_vld   <= s1_vld;
      s3_vld   <= s2_vld;
      s4_vld   <= s3_vld;
      outvalid <= s4_vld && s4_last;
      if (s4_vld && s4_last) begin
        out     <= act_out;
        satFlag <= act_sat;
      end
    end
  end

  // Datapath registers; first/last tags ride alongside the data
  always_ff @(posedge clk) begin
    s0_dat   <= myinput;
    s0_beat  <= beat;
    s0_first <= (beat == '0);
    s0_last  <= (beat == BW'(NB - 1));

    s1_w     <= wmem[s0_beat] & lane_mask;
    s1_x     <= s0_dat & lane_mask;
    s1_first <= s0_first;
    s1_last  <= s0_last;

    for (int k = 0; k < lanes; k++) begin
      s2_prod[k] <= $signed(s1_w[k*dataWidth +: dataWidth]) * $signed(s1_x[k*dataWidth +: dataWidth]);
    end
    s2_first <= s1_first;
    s2_last  <= s1_last;

    s3_sum   <= lane_sum;
    s3_first <= s2_first;
    s3_last  <= s2_last;

    if (s3_vld) acc <= s3_first ? s3_sum : acc + s3_sum;
    s4_last  <= s3_last;
  end

endmodule
